// File: rtl/sm83_alu_flags_ctx_pkg.sv
`default_nettype none
// sm83_flags_pkg: context type, secondary-carry source encoding and flag bit positions. Rev 1.0
package sm83_flags_pkg;

  localparam int CTX_W = 7;

  typedef struct packed {
    logic zero;
    logic neg;
    logic hc;
    logic daa;
    logic pri_c;
    logic sec_c;
    logic spare;
  } flags_ctx_t;

  typedef enum logic [1:0] {
    SC_CARRY = 2'd0,
    SC_SHIFT = 2'd1,
    SC_DAA   = 2'd2,
    SC_ZERO  = 2'd3
  } sc_src_e;

  function automatic int z_bit(input int ws);
    return ws - 1;
  endfunction

  function automatic int n_bit(input int ws);
    return ws - 2;
  endfunction

  function automatic int h_bit(input int ws);
    return ws - 3;
  endfunction

  function automatic int c_bit(input int ws);
    return ws - 4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm83_alu_flags_ctx_if.sv
`default_nettype none
// sm83_alu_flags_ctx_if: control/data bundle between ALU control and the flag block. Rev 1.0
interface sm83_alu_flags_ctx_if #(
  parameter int WORD_SIZE   = 8,
  parameter int STACK_DEPTH = 4
);
  logic [WORD_SIZE-1:0] din;
  logic [WORD_SIZE-1:0] dout;
  logic flags_bus, flags_alu;
  logic zero_we, zero_loop, half_carry_we, half_carry_cpl, daa_carry_we;
  logic neg_we, neg_set, neg_clr;
  logic carry_we, sec_carry_we, sec_carry_sh, sec_carry_daa, sec_carry_sel, carry_set, carry_cpl;
  logic zero_in, carry_in, shift_out_in, daa_carry_in;
  logic ctx_push, ctx_pop, err_clr;
  logic zero, half_carry, daa_carry, neg, carry, pri_carry;
  logic [$clog2(STACK_DEPTH+1)-1:0] ctx_level;
  logic ctx_full, ctx_empty, ctx_ovf, ctx_unf;

  modport master (
    output din, flags_bus, flags_alu, zero_we, zero_loop, half_carry_we, half_carry_cpl,
           daa_carry_we, neg_we, neg_set, neg_clr, carry_we, sec_carry_we, sec_carry_sh,
           sec_carry_daa, sec_carry_sel, carry_set, carry_cpl, zero_in, carry_in,
           shift_out_in, daa_carry_in, ctx_push, ctx_pop, err_clr,
    input  dout, zero, half_carry, daa_carry, neg, carry, pri_carry,
           ctx_level, ctx_full, ctx_empty, ctx_ovf, ctx_unf
  );

  modport slave (
    input  din, flags_bus, flags_alu, zero_we, zero_loop, half_carry_we, half_carry_cpl,
           daa_carry_we, neg_we, neg_set, neg_clr, carry_we, sec_carry_we, sec_carry_sh,
           sec_carry_daa, sec_carry_sel, carry_set, carry_cpl, zero_in, carry_in,
           shift_out_in, daa_carry_in, ctx_push, ctx_pop, err_clr,
    output dout, zero, half_carry, daa_carry, neg, carry, pri_carry,
           ctx_level, ctx_full, ctx_empty, ctx_ovf, ctx_unf
  );
endinterface
`default_nettype wire

// File: rtl/sm83_alu_flags_ctx_stack.sv
`default_nettype none
// sm83_flags_ctx_stack: LIFO of flag contexts with exchange and sticky overflow/underflow. Rev 1.0
module sm83_flags_ctx_stack
  import sm83_flags_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type CTX_T = flags_ctx_t,
  parameter int  LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             err_clr_i,
  input  CTX_T             wr_data_i,
  output CTX_T             top_o,
  output logic             restore_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o,
  output logic             unf_o
);
  logic [LVL_W-1:0] sp_q, sp_d, wr_idx_w;
  CTX_T             entry_q [DEPTH];
  logic             ovf_q, unf_q;
  logic             empty_w, full_w, exch_w, do_push_w, do_pop_w, new_ovf_w, new_unf_w;

  assign empty_w   = (sp_q == '0);
  assign full_w    = (sp_q == LVL_W'(DEPTH));
  assign exch_w    = push_i & pop_i & ~empty_w;
  assign do_push_w = push_i & ~pop_i & ~full_w;
  assign do_pop_w  = pop_i & ~push_i & ~empty_w;
  assign new_ovf_w = push_i & ~pop_i & full_w;
  // Pop on empty, with or without a simultaneous push, is an underflow.
  assign new_unf_w = pop_i & empty_w;
  assign restore_o = exch_w | do_pop_w;
  assign wr_idx_w  = exch_w ? (sp_q - LVL_W'(1)) : sp_q;

  always_comb begin
    sp_d = sp_q;
    if (do_push_w) begin
      sp_d = sp_q + LVL_W'(1);
    end else if (do_pop_w) begin
      sp_d = sp_q - LVL_W'(1);
    end
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (LVL_W'(i + 1) == sp_q) top_o = entry_q[i];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= (ovf_q & ~err_clr_i) | new_ovf_w;
      unf_q <= (unf_q & ~err_clr_i) | new_unf_w;
      for (int i = 0; i < DEPTH; i++) begin
        if ((do_push_w | exch_w) && (LVL_W'(i) == wr_idx_w)) entry_q[i] <= wr_data_i;
      end
    end
  end

  assign level_o = sp_q;
  assign full_o  = full_w;
  assign empty_o = empty_w;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule
`default_nettype wire

// File: rtl/sm83_alu_flags_ctx.sv
`default_nettype none
// sm83_alu_flags_ctx: SM83 Z/N/H/C flag register with context stack. Rev 1.0
// Build option SM83_ALU_FLAGS_CTX_LOWNIB_EN makes dout's low bits a saved general-purpose register.
module sm83_alu_flags_ctx
  import sm83_flags_pkg::*;
#(
  parameter int WORD_SIZE   = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                nreset,
  sm83_alu_flags_ctx_if.slave bus
);
  localparam int ZB    = z_bit(WORD_SIZE);
  localparam int NB    = n_bit(WORD_SIZE);
  localparam int HB    = h_bit(WORD_SIZE);
  localparam int CB    = c_bit(WORD_SIZE);
  localparam int LOW_W = WORD_SIZE - 4;

`ifdef SM83_ALU_FLAGS_CTX_LOWNIB_EN
  typedef struct packed {
    flags_ctx_t       f;
    logic [LOW_W-1:0] low;
  } ctx_t;
`else
  typedef struct packed {
    flags_ctx_t f;
  } ctx_t;
`endif

  ctx_t             live_q, live_d, upd_w, top_w;
  logic             restore_w, from_bus_w;
  logic [LOW_W-1:0] low_w;
  sc_src_e          sc_src_w;

  assign from_bus_w = bus.flags_bus & ~bus.flags_alu;
  assign sc_src_w   = sc_src_e'({bus.sec_carry_daa, bus.sec_carry_sh});

  always_comb begin
    upd_w = live_q;
    if (bus.zero_we) begin
      upd_w.f.zero = from_bus_w ? bus.din[ZB] : bus.zero_in;
      if (bus.zero_loop) upd_w.f.zero = upd_w.f.zero & live_q.f.zero;
    end
    if (bus.neg_we) upd_w.f.neg = ~bus.neg_clr & (bus.neg_set | (from_bus_w & bus.din[NB]));
    if (bus.half_carry_we) upd_w.f.hc = from_bus_w ? bus.din[HB] : bus.carry_in;
    if (bus.daa_carry_we) upd_w.f.daa = from_bus_w ? bus.din[HB] : bus.carry_in;
    // The primary carry is left alone while the secondary carry is being loaded.
    if (bus.carry_we && !bus.sec_carry_we) upd_w.f.pri_c = from_bus_w ? bus.din[CB] : bus.carry_in;
    if (bus.sec_carry_we) begin
      case (sc_src_w)
        SC_CARRY: upd_w.f.sec_c = bus.carry_in;
        SC_SHIFT: upd_w.f.sec_c = bus.shift_out_in;
        SC_DAA:   upd_w.f.sec_c = bus.daa_carry_in;
        default:  upd_w.f.sec_c = 1'b0;
      endcase
    end
    upd_w.f.spare = 1'b0;
`ifdef SM83_ALU_FLAGS_CTX_LOWNIB_EN
    if (from_bus_w && bus.zero_we) upd_w.low = bus.din[LOW_W-1:0];
`endif
    live_d = restore_w ? top_w : upd_w;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      live_q <= '0;
    end else begin
      live_q <= live_d;
    end
  end

  sm83_flags_ctx_stack #(
    .DEPTH (STACK_DEPTH),
    .CTX_T (ctx_t)
  ) u_stack (
    .clk       (clk),
    .nreset    (nreset),
    .push_i    (bus.ctx_push),
    .pop_i     (bus.ctx_pop),
    .err_clr_i (bus.err_clr),
    .wr_data_i (live_q),
    .top_o     (top_w),
    .restore_o (restore_w),
    .level_o   (bus.ctx_level),
    .full_o    (bus.ctx_full),
    .empty_o   (bus.ctx_empty),
    .ovf_o     (bus.ctx_ovf),
    .unf_o     (bus.ctx_unf)
  );

`ifdef SM83_ALU_FLAGS_CTX_LOWNIB_EN
  assign low_w = live_q.low;
`else
  logic unused_w;
  assign unused_w = ^bus.din[LOW_W-1:0];
  assign low_w    = '0;
`endif

  assign bus.zero       = live_q.f.zero;
  assign bus.neg        = live_q.f.neg;
  assign bus.daa_carry  = live_q.f.daa;
  assign bus.pri_carry  = live_q.f.pri_c;
  assign bus.half_carry = live_q.f.hc ^ bus.half_carry_cpl;
  assign bus.carry      = (bus.carry_set | (bus.sec_carry_sel ? live_q.f.sec_c : live_q.f.pri_c))
                          ^ bus.carry_cpl;
  assign bus.dout       = {bus.zero, bus.neg, bus.half_carry, bus.carry, low_w};

endmodule
`default_nettype wire

// File: tb/tb_sm83_alu_flags_ctx.sv
`default_nettype none
// tb_sm83_alu_flags_ctx: scoreboard bench with a queue-based behavioural flag/stack model.
module tb_sm83_alu_flags_ctx;
  localparam int DEPTH = 4;
`ifdef SM83_ALU_FLAGS_CTX_LOWNIB_EN
  localparam bit LOWNIB = 1'b1;
`else
  localparam bit LOWNIB = 1'b0;
`endif

  typedef struct packed {
    bit [7:0] din;
    bit fb, zwe, zloop, hwe, hcpl, dwe, nwe, nset, nclr, cwe, swe, ssh, sdaa, ssel;
    bit cset, ccpl, zin, cin, sin, dcin, push, pop, eclr;
  } stim_t;

  typedef struct packed {
    bit [7:0] dout;
    bit z, h, d, n, c, pc;
    bit [2:0] lvl;
    bit full, empty, ovf, unf;
  } exp_t;

  typedef struct packed {
    bit z, n, h, d, pc, sc;
    bit [3:0] low;
  } mctx_t;

  logic  clk = 1'b0;
  logic  nreset;
  int    n_cmp = 0;
  int    n_bad = 0;
  exp_t  q[$];
  mctx_t m;
  mctx_t stk[$];
  bit    m_ovf, m_unf;

  sm83_alu_flags_ctx_if #(.WORD_SIZE(8), .STACK_DEPTH(DEPTH)) bus ();
  sm83_alu_flags_ctx #(.WORD_SIZE(8), .STACK_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    bus.din = s.din;               bus.flags_bus = s.fb;         bus.flags_alu = ~s.fb;
    bus.zero_we = s.zwe;           bus.zero_loop = s.zloop;      bus.half_carry_we = s.hwe;
    bus.half_carry_cpl = s.hcpl;   bus.daa_carry_we = s.dwe;     bus.neg_we = s.nwe;
    bus.neg_set = s.nset;          bus.neg_clr = s.nclr;         bus.carry_we = s.cwe;
    bus.sec_carry_we = s.swe;      bus.sec_carry_sh = s.ssh;     bus.sec_carry_daa = s.sdaa;
    bus.sec_carry_sel = s.ssel;    bus.carry_set = s.cset;       bus.carry_cpl = s.ccpl;
    bus.zero_in = s.zin;           bus.carry_in = s.cin;         bus.shift_out_in = s.sin;
    bus.daa_carry_in = s.dcin;     bus.ctx_push = s.push;        bus.ctx_pop = s.pop;
    bus.err_clr = s.eclr;
  endtask

  function automatic exp_t expect_now(input stim_t s);
    exp_t e;
    e.h     = m.h ^ s.hcpl;
    e.c     = (s.cset | (s.ssel ? m.sc : m.pc)) ^ s.ccpl;
    e.z     = m.z;
    e.n     = m.n;
    e.d     = m.d;
    e.pc    = m.pc;
    e.dout  = {m.z, m.n, e.h, e.c, (LOWNIB ? m.low : 4'h0)};
    e.lvl   = 3'(stk.size());
    e.full  = (stk.size() == DEPTH);
    e.empty = (stk.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic model_step(input stim_t s);
    mctx_t n;
    bit    nov, nun;
    n = m; nov = 1'b0; nun = 1'b0;
    if (s.zwe) n.z = (s.fb ? s.din[7] : s.zin) & (s.zloop ? m.z : 1'b1);
    if (s.nwe) n.n = s.nclr ? 1'b0 : (s.nset | (s.fb & s.din[6]));
    if (s.hwe) n.h = s.fb ? s.din[5] : s.cin;
    if (s.dwe) n.d = s.fb ? s.din[5] : s.cin;
    if (s.cwe && !s.swe) n.pc = s.fb ? s.din[4] : s.cin;
    if (s.swe) n.sc = s.sdaa ? (s.ssh ? 1'b0 : s.dcin) : (s.ssh ? s.sin : s.cin);
    if (LOWNIB && s.fb && s.zwe) n.low = s.din[3:0];
    if (s.push && s.pop) begin
      if (stk.size() == 0) nun = 1'b1;
      else begin
        n = stk[stk.size()-1];
        stk[stk.size()-1] = m;
      end
    end else if (s.push) begin
      if (stk.size() == DEPTH) nov = 1'b1;
      else stk.push_back(m);
    end else if (s.pop) begin
      if (stk.size() == 0) nun = 1'b1;
      else n = stk.pop_back();
    end
    m_ovf = (m_ovf && !s.eclr) || nov;
    m_unf = (m_unf && !s.eclr) || nun;
    m = n;
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    apply(s);
    q.push_back(expect_now(s));
    model_step(s);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t load(input bit [7:0] d);
    stim_t s;
    s = '0;
    s.din = d; s.fb = 1'b1;
    s.zwe = 1'b1; s.nwe = 1'b1; s.hwe = 1'b1; s.dwe = 1'b1; s.cwe = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t    s;
    bit [31:0] r;
    r      = $urandom;
    s      = r[30:0];
    s.push = ($urandom_range(3) == 0);
    s.pop  = ($urandom_range(3) == 0);
    s.eclr = ($urandom_range(11) == 0);
    return s;
  endfunction

  task automatic reset_checks(input bit c, input bit h);
    chk("rst_dout",  32'(bus.dout), {24'h0, 2'b00, h, c, 4'h0});
    chk("rst_zero",  32'(bus.zero), 32'd0);
    chk("rst_neg",   32'(bus.neg), 32'd0);
    chk("rst_daa",   32'(bus.daa_carry), 32'd0);
    chk("rst_pri",   32'(bus.pri_carry), 32'd0);
    chk("rst_carry", 32'(bus.carry), 32'(c));
    chk("rst_hc",    32'(bus.half_carry), 32'(h));
    chk("rst_level", 32'(bus.ctx_level), 32'd0);
    chk("rst_empty", 32'(bus.ctx_empty), 32'd1);
    chk("rst_full",  32'(bus.ctx_full), 32'd0);
    chk("rst_ovf",   32'(bus.ctx_ovf), 32'd0);
    chk("rst_unf",   32'(bus.ctx_unf), 32'd0);
  endtask

  task automatic mid_reset();
    stim_t s;
    s = idle(); s.cset = 1'b1; s.hcpl = 1'b1;
    @(posedge clk);
    #3;
    apply(s);
    nreset = 1'b0;
    #1;
    reset_checks(1'b1, 1'b1);
    m = '0; stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk);
    #3 nreset = 1'b1;
  endtask

  // Scoreboard monitor: one expected record per driven cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dout",      32'(bus.dout), 32'(e.dout));
        chk("zero",      32'(bus.zero), 32'(e.z));
        chk("half",      32'(bus.half_carry), 32'(e.h));
        chk("daa",       32'(bus.daa_carry), 32'(e.d));
        chk("neg",       32'(bus.neg), 32'(e.n));
        chk("carry",     32'(bus.carry), 32'(e.c));
        chk("pri_carry", 32'(bus.pri_carry), 32'(e.pc));
        chk("level",     32'(bus.ctx_level), 32'(e.lvl));
        chk("full",      32'(bus.ctx_full), 32'(e.full));
        chk("empty",     32'(bus.ctx_empty), 32'(e.empty));
        chk("ovf",       32'(bus.ctx_ovf), 32'(e.ovf));
        chk("unf",       32'(bus.ctx_unf), 32'(e.unf));
      end
    end
  end

  initial begin
    stim_t s;
    m = '0; m_ovf = 1'b0; m_unf = 1'b0;
    nreset = 1'b1;
    apply(idle());
    #1 nreset = 1'b0;
    #1 reset_checks(1'b0, 1'b0);
    #20 nreset = 1'b1;

    drive(load(8'hF0)); drive(idle());
    s = idle(); s.zwe = 1; s.zloop = 1; s.hwe = 1; s.dwe = 1; s.cwe = 1; s.cin = 1;
    drive(s); drive(idle());

    drive(load(8'hA0));
    s = idle(); s.push = 1; drive(s);
    drive(load(8'h50));
    s = idle(); s.pop = 1; drive(s);
    drive(idle());

    for (int i = 0; i < 5; i++) begin
      s = load(8'((i + 1) * 16)); s.push = 1; drive(s);
    end
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.pop = 1; drive(s);
    end
    s = idle(); s.eclr = 1; drive(s);
    s = idle(); s.pop = 1; s.eclr = 1; drive(s);
    s = idle(); s.eclr = 1; drive(s);

    drive(load(8'h80));
    s = idle(); s.push = 1; drive(s);
    drive(load(8'h10));
    s = idle(); s.push = 1; s.pop = 1; drive(s);
    drive(idle());
    s = idle(); s.pop = 1; drive(s);
    s = idle(); s.push = 1; s.pop = 1; drive(s);
    s = idle(); s.eclr = 1; drive(s);

    drive(load(8'h00));
    s = idle(); s.swe = 1; s.ssh = 1; s.sin = 1; s.ssel = 1; drive(s);
    s = idle(); s.ssel = 1; drive(s);
    s.ccpl = 1; drive(s);

    drive(load(8'hF0));
    s = idle(); s.push = 1; drive(s); drive(s);
    mid_reset();
    s = idle(); s.pop = 1; drive(s);
    drive(idle());

    for (int i = 0; i < 3000; i++) drive(rand_stim());

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d records pending, expected 0", q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sm83_alu_flags_ctx.md
Name: sm83_alu_flags_ctx

Overview:
- Next-generation SM83 ALU flag register: Z/N/H/C plus hidden DAA half-carry and secondary carry.
- Adds asynchronous reset, a parametrised LIFO context stack (save/restore of the full flag state) and sticky stack-error reporting.
- Sits between ALU control and the data bus, same position as the current flag block.
- Used for interrupt entry/exit and multi-step microcode needing temporary flag preservation.

Parameters:
WORD_SIZE, 8, data bus width; Z/N/H/C occupy bits WORD_SIZE-1..WORD_SIZE-4.
STACK_DEPTH, 4, number of saved contexts (>=1).
CTX_W, 7, packed context width {zero, neg, hc, daa, pri_c, sec_c, spare}; fixed, not overridable.

Ports:
clk  in  1  clock, rising edge.
nreset  in  1  asynchronous active-low reset.
din  in  WORD_SIZE  flags from data bus.
dout  out  WORD_SIZE  flags to data bus.
flags_bus, flags_alu  in  1  source select, exactly one high on any write.
zero_we, zero_loop, half_carry_we, half_carry_cpl, daa_carry_we  in  1  as in the current flag block.
neg_we, neg_set, neg_clr  in  1  subtract flag control.
carry_we, sec_carry_we, sec_carry_sh, sec_carry_daa, sec_carry_sel, carry_set, carry_cpl  in  1  carry control.
zero_in, carry_in, shift_out_in, daa_carry_in  in  1  ALU-side flag sources.
ctx_push  in  1  save live context.
ctx_pop  in  1  restore top context.
err_clr  in  1  clear sticky errors.
zero, half_carry, daa_carry, neg, carry, pri_carry  out  1  flag outputs.
ctx_level  out  $clog2(STACK_DEPTH+1)  occupied entries.
ctx_full, ctx_empty  out  1  stack status.
ctx_ovf, ctx_unf  out  1  sticky overflow/underflow.

Behaviour:
- Reset (nreset low, async): all flag regs 0, stack pointer 0, entries 0, ctx_ovf = ctx_unf = 0.
  - Outputs after reset: carry = carry_set^carry_cpl, half_carry = half_carry_cpl, ctx_empty = 1.
- Flag writes, one-cycle latency, registered on clk rising edge:
  - zero: new = din[Z] or zero_in; zero_loop ANDs new into current value.
  - neg: neg_set | (flags_bus & din[N]); neg_clr forces 0.
  - hc/daa/pri_c: write din[H]/din[H]/din[C] or carry_in.
  - pri_c writes only when carry_we & !sec_carry_we.
  - sec_c: {daa,sh} 00 carry_in, 01 shift_out_in, 10 daa_carry_in, 11 zero.
- Combinational outputs:
  - carry = (carry_set | (sec_carry_sel ? sec_c : pri_c)) ^ carry_cpl.
  - half_carry = hc ^ half_carry_cpl.
  - dout low bits = 0.
- Push, not full: entry[sp] <= pre-edge live context; sp+1. Flag writes in the same cycle still apply to the live regs.
- Pop, not empty: live regs <= entry[sp-1]; sp-1. The restore overrides any flag write in the same cycle.
- Push+pop same cycle, sp>0: exchange. Top entry <= live context, live <= old top; sp unchanged.
- Push+pop same cycle, empty: treated as a nop; ctx_unf set.
- Push when full: no store, sp unchanged, ctx_ovf <= 1.
- Pop when empty: live unchanged, ctx_unf <= 1.
- Sticky errors: err_clr clears them, but a same-cycle new error wins (stays set).
- Status outputs: ctx_full = (sp==STACK_DEPTH), ctx_empty = (sp==0), ctx_level = sp; all registered-state derived.
- Reset mid-operation discards all saved contexts.

Optional Feature:
SM83_ALU_FLAGS_CTX_LOWNIB_EN
- Defined: dout[WORD_SIZE-5:0] is a general-purpose register.
  - Written from din when flags_bus & zero_we.
  - Included in saved/restored contexts (CTX_W grows by WORD_SIZE-4).
  - Reset value 0.
- Undefined: low bits read 0; no storage.

Decomposition:
- Package sm83_flags_pkg:
  - flag bit index constants Z/N/H/C as functions of WORD_SIZE;
  - packed struct flags_ctx_t;
  - sec-carry source enum {SC_CARRY, SC_SHIFT, SC_DAA, SC_ZERO}.
- One sub-module: sm83_flags_ctx_stack. It is a generic LIFO of flags_ctx_t holding the pointer, the full/empty/error logic and exchange.
- The top level keeps the flag-update logic and the output muxing.

Test Plan:
- Reset: nreset low mid-cycle -> all outputs cleared asynchronously, ctx_empty=1, ctx_level=0.
- Bus load then ALU: din=0xF0 with flags_bus and all we -> dout=0xF0. Then flags_alu, zero_loop=1, zero_in=0 -> zero=0, others per carry_in.
- Push/pop round trip: flags 0xA0, push; load 0x50; pop -> dout=0xA0, ctx_level 1->0.
- Overflow: STACK_DEPTH=4, five pushes -> ctx_full=1, ctx_ovf=1, level=4. Four pops restore in LIFO order; a fifth pop -> ctx_unf=1. Then err_clr -> both 0.
- Exchange: push 0x80, load 0x10, push+pop same cycle -> live 0x80, top entry 0x10, level 1.
- Carry mux: sec_carry_we with sh=1, shift_out_in=1, pri_c=0, sec_carry_sel=1 -> carry=1. Add carry_cpl -> carry=0. Confirm pri_carry unchanged.
